// File: rtl/bram_burst_master.sv
// Initiator for one port of a single-cycle-latency BRAM: single-word writes and
// incrementing read bursts, with read data returned through a 4-deep response FIFO.
module bram_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [LEN_WIDTH-1:0]  req_length,
    input  logic [DATA_WIDTH-1:0] req_write_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_last,
    output logic                  readEnable,
    output logic                  writeEnable,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] writeData,
    input  logic [DATA_WIDTH-1:0] readData
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1'b1);
    localparam logic [LEN_WIDTH:0]    REM_ONE  = (LEN_WIDTH + 1)'(1'b1);

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   cur_addr_r, cur_addr_s;
    logic [ADDR_WIDTH-1:0]   addr_hold_r;
    logic [LEN_WIDTH:0]      remaining_r, remaining_s;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic                    inflight_r;
    logic                    inflight_last_r;

    logic [DATA_WIDTH-1:0]   fifo_data_r [4];
    logic [3:0]              fifo_last_r;
    logic [1:0]              wr_ptr_r, rd_ptr_r;
    logic [2:0]              count_r;

    logic                    accept_s, credit_ok_s, issue_s, last_issue_s;
    logic                    re_s, we_s, push_s, pop_s;
    logic [ADDR_WIDTH-1:0]   addr_s;

    // Credit counts the queued words plus the read still in the BRAM pipe; pops are ignored.
    assign credit_ok_s = ({1'b0, count_r} + {3'b000, inflight_r}) < 4'd4;

    assign req_ready   = (state_r == IDLE) && reset;
    assign accept_s    = req_valid && req_ready;
    assign push_s      = inflight_r;
    assign pop_s       = resp_valid && resp_ready;

    assign resp_valid  = reset && (count_r != 3'd0);
    assign resp_data   = reset ? fifo_data_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
    assign resp_last   = reset && fifo_last_r[rd_ptr_r];

    assign readEnable  = re_s && reset;
    assign writeEnable = we_s && reset;
    assign address     = reset ? addr_s : {ADDR_WIDTH{1'b0}};
    assign writeData   = reset ? wdata_r : {DATA_WIDTH{1'b0}};

    // Next-state, BRAM port drive and burst bookkeeping.
    always_comb begin
        state_s      = state_r;
        cur_addr_s   = cur_addr_r;
        remaining_s  = remaining_r;
        re_s         = 1'b0;
        we_s         = 1'b0;
        addr_s       = addr_hold_r;
        issue_s      = 1'b0;
        last_issue_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    cur_addr_s = req_address;
                    if (req_write) begin
                        state_s = WRITE;
                    end else begin
                        state_s     = READ;
                        remaining_s = {1'b0, req_length} + REM_ONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                we_s    = 1'b1;
                addr_s  = cur_addr_r;
                state_s = IDLE;
            end
            READ: begin
                if (credit_ok_s) begin
                    issue_s     = 1'b1;
                    re_s        = 1'b1;
                    addr_s      = cur_addr_r;
                    cur_addr_s  = cur_addr_r + ADDR_ONE;
                    remaining_s = remaining_r - REM_ONE;
                    if (remaining_r == REM_ONE) begin
                        last_issue_s = 1'b1;
                        state_s      = IDLE;
                    end else begin
                        state_s = READ;
                    end
                end else begin
                    state_s = READ;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control state, request latches and read pipeline tag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r         <= IDLE;
            cur_addr_r      <= {ADDR_WIDTH{1'b0}};
            addr_hold_r     <= {ADDR_WIDTH{1'b0}};
            remaining_r     <= {(LEN_WIDTH + 1){1'b0}};
            wdata_r         <= {DATA_WIDTH{1'b0}};
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            state_r         <= state_s;
            cur_addr_r      <= cur_addr_s;
            addr_hold_r     <= addr_s;
            remaining_r     <= remaining_s;
            inflight_r      <= issue_s;
            inflight_last_r <= last_issue_s;
            if (accept_s && req_write) begin
                wdata_r <= req_write_data;
            end
        end
    end

    // Response FIFO: push the BRAM word one cycle after its read was issued.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo_data_r[i] <= {DATA_WIDTH{1'b0}};
            end
            fifo_last_r <= 4'b0000;
            wr_ptr_r    <= 2'd0;
            rd_ptr_r    <= 2'd0;
            count_r     <= 3'd0;
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= readData;
                fifo_last_r[wr_ptr_r] <= inflight_last_r;
                wr_ptr_r              <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_burst_master.sv
// Scoreboard bench for bram_burst_master with a behavioural one-cycle-latency BRAM.
module tb_bram_burst_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_address;
    logic [3:0]  req_length;
    logic [31:0] req_write_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_last;
    logic        readEnable;
    logic        writeEnable;
    logic [7:0]  address;
    logic [31:0] writeData;
    logic [31:0] readData;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q [$];   // {last, data}
    logic [7:0]  addr_q [$];  // expected read addresses
    logic [39:0] wr_q [$];    // expected {address, data} writes
    logic [31:0] mem [256];
    logic [31:0] shadow [256];

    always #5 clock = ~clock;

    bram_burst_master dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_length(req_length), .req_write_data(req_write_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_last(resp_last),
        .readEnable(readEnable), .writeEnable(writeEnable), .address(address),
        .writeData(writeData), .readData(readData)
    );

    function automatic logic [31:0] pattern(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // BRAM model: contents reload to a known pattern while reset is low.
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
        end else begin
            if (writeEnable) mem[address] <= writeData;
            if (readEnable) readData <= mem[address];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: BRAM port addresses/writes and response stream against the scoreboard.
    always @(negedge clock) begin
        logic [32:0] e;
        logic [39:0] w;
        if (reset === 1'b1) begin
            if (readEnable) begin
                check_eq("rw_exclusive", {63'd0, writeEnable}, 64'd0);
                if (addr_q.size() == 0) check_eq("spurious_read", 64'd1, 64'd0);
                else check_eq("read_address", {56'd0, address}, {56'd0, addr_q.pop_front()});
            end
            if (writeEnable) begin
                if (wr_q.size() == 0) check_eq("spurious_write", 64'd1, 64'd0);
                else begin
                    w = wr_q.pop_front();
                    check_eq("write_addr_data", {24'd0, address, writeData}, {24'd0, w});
                end
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) check_eq("spurious_resp", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check_eq("resp_data", {32'd0, resp_data}, {32'd0, e[31:0]});
                    check_eq("resp_last", {63'd0, resp_last}, {63'd0, e[32]});
                end
            end
        end
    end

    task automatic reset_shadow();
        for (int i = 0; i < 256; i++) shadow[i] = pattern(i);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_ctrl", {59'd0, req_ready, resp_valid, resp_last, readEnable, writeEnable}, 64'd0);
        check_eq("rst_address", {56'd0, address}, 64'd0);
        check_eq("rst_writeData", {32'd0, writeData}, 64'd0);
        check_eq("rst_resp_data", {32'd0, resp_data}, 64'd0);
    endtask

    task automatic send(input logic w, input logic [7:0] a, input logic [3:0] len, input logic [31:0] d);
        int n;
        logic [7:0] ad;
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = w; req_address = a; req_length = len; req_write_data = d;
        n = 0;
        forever begin
            @(negedge clock);
            if (req_ready) break;
            n++;
            if (n > 200) begin
                check_eq("req_timeout", 64'd1, 64'd0);
                break;
            end
        end
        if (w) begin
            wr_q.push_back({a, d});
            shadow[a] = d;
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                ad = a + 8'(i);
                addr_q.push_back(ad);
                exp_q.push_back({(i == int'(len)), shadow[ad]});
            end
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        check_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int nre;
        int nv;
        reset = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_address = 8'h33;
        req_length = 4'h3; req_write_data = 32'd0; resp_ready = 1'b0;
        reset_shadow();

        // Reset held with a pending request
        repeat (3) begin
            @(negedge clock);
            check_reset_outputs();
        end
        @(posedge clock); #1;
        req_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        check_eq("ready_after_reset", {63'd0, req_ready}, 64'd1);

        // Write then read with latency check
        resp_ready = 1'b1;
        send(1'b1, 8'h00, 4'h0, 32'd10);
        send(1'b1, 8'h01, 4'h0, 32'd11);
        send(1'b0, 8'h00, 4'h1, 32'd0);
        @(negedge clock); check_eq("latency_c0", {63'd0, resp_valid}, 64'd0);
        @(negedge clock); check_eq("latency_c1", {63'd0, resp_valid}, 64'd0);
        @(negedge clock); check_eq("latency_c2", {63'd0, resp_valid}, 64'd1);
        check_eq("first_word", {32'd0, resp_data}, 64'd10);
        drain("drain_wr_rd");

        // Full-throughput 16-beat burst
        send(1'b0, 8'h20, 4'hF, 32'd0);
        for (int i = 0; i < 19; i++) begin
            @(negedge clock);
            check_eq("burst_re", {63'd0, readEnable}, {63'd0, (i < 16)});
            check_eq("burst_valid", {63'd0, resp_valid}, {63'd0, (i >= 2 && i < 18)});
        end
        drain("drain_burst");

        // Backpressure: only four reads may be outstanding
        @(posedge clock); #1;
        resp_ready = 1'b0;
        send(1'b0, 8'h40, 4'h7, 32'd0);
        nre = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (readEnable) nre++;
        end
        check_eq("bp_issued", 64'(nre), 64'd4);
        check_eq("bp_re_low", {63'd0, readEnable}, 64'd0);
        check_eq("bp_valid", {63'd0, resp_valid}, 64'd1);
        check_eq("bp_head", {32'd0, resp_data}, {32'd0, pattern(8'h40)});
        @(posedge clock); #1;
        resp_ready = 1'b1;
        drain("drain_bp");

        // Address wrap
        send(1'b0, 8'hFE, 4'h3, 32'd0);
        drain("drain_wrap");
        check_eq("wrap_addrs_used", 64'(addr_q.size()), 64'd0);

        // Reset in the middle of a burst
        send(1'b0, 8'h80, 4'hF, 32'd0);
        repeat (3) @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check_reset_outputs();
        end
        exp_q.delete();
        addr_q.delete();
        reset_shadow();
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check_eq("ready_after_midreset", {63'd0, req_ready}, 64'd1);
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (resp_valid || readEnable) nv++;
        end
        check_eq("no_resp_after_reset", 64'(nv), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
